// File: rtl/us_mac_rx_dispatch.sv
// MAC RX dispatch: filters stripped frames on destination MAC and
// routes them by EtherType to the IP or ARP path, with frame counters.
module us_mac_rx_dispatch #(
  parameter logic [15:0] ETH_TYPE_IP  = 16'h0800,
  parameter logic [15:0] ETH_TYPE_ARP = 16'h0806,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int unsigned MAX_BEATS    = 190
) (
  input  logic        rx_axis_aclk,
  input  logic        rx_axis_aresetn,
  input  logic [63:0] rx_frame_axis_tdata,
  input  logic [7:0]  rx_frame_axis_tkeep,
  input  logic        rx_frame_axis_tvalid,
  input  logic        rx_frame_axis_tuser,
  input  logic        rx_frame_axis_tlast,
  input  logic [47:0] recv_dst_mac_addr,
  input  logic [15:0] recv_type,
  input  logic [47:0] local_mac_addr,
  output logic [63:0] ip_rx_axis_tdata,
  output logic [7:0]  ip_rx_axis_tkeep,
  output logic        ip_rx_axis_tvalid,
  output logic        ip_rx_axis_tlast,
  output logic        ip_rx_axis_tuser,
  output logic [63:0] arp_rx_axis_tdata,
  output logic [7:0]  arp_rx_axis_tkeep,
  output logic        arp_rx_axis_tvalid,
  output logic        arp_rx_axis_tlast,
  output logic        arp_rx_axis_tuser,
  output logic [31:0] rx_ip_frames,
  output logic [31:0] rx_arp_frames,
  output logic [31:0] rx_drop_frames,
  output logic [31:0] rx_err_frames
);

  typedef enum logic [1:0] {
    SOF,
    FWD_IP,
    FWD_ARP,
    DROP
  } state_t;

  localparam logic [9:0] LP_MAX = 10'(MAX_BEATS);

  state_t     r_state;
  logic [9:0] r_beat_cnt;
  logic       r_err_seen;
  logic       r_trunc;

  logic       w_addr_ok;
  logic       w_is_ip;
  logic       w_is_arp;
  logic [9:0] w_cnt;
  logic       w_err;
  logic       w_fwd_ip;
  logic       w_fwd_arp;
  logic       w_last;
  logic       w_user;
  logic       w_trunc;
  logic       w_inc_ip;
  logic       w_inc_arp;
  logic       w_inc_drop;
  logic       w_inc_err;
  state_t     w_nstate;

  assign w_addr_ok = (recv_dst_mac_addr == local_mac_addr) ||
                     (ACCEPT_BCAST && (&recv_dst_mac_addr));
  assign w_is_ip   = w_addr_ok && (recv_type == ETH_TYPE_IP);
  assign w_is_arp  = w_addr_ok && (recv_type == ETH_TYPE_ARP);
  assign w_cnt     = r_beat_cnt + 10'd1;
  assign w_err     = r_err_seen | rx_frame_axis_tuser;

  always_comb begin
    w_fwd_ip   = 1'b0;
    w_fwd_arp  = 1'b0;
    w_last     = rx_frame_axis_tlast;
    w_user     = rx_frame_axis_tuser;
    w_trunc    = 1'b0;
    w_inc_ip   = 1'b0;
    w_inc_arp  = 1'b0;
    w_inc_drop = 1'b0;
    w_inc_err  = 1'b0;
    w_nstate   = r_state;
    if (rx_frame_axis_tvalid) begin
      unique case (r_state)
        SOF: begin
          unique case (1'b1)
            w_is_ip: begin
              w_fwd_ip = 1'b1;
              w_nstate = FWD_IP;
            end
            w_is_arp: begin
              w_fwd_arp = 1'b1;
              w_nstate  = FWD_ARP;
            end
            default: begin
              w_nstate   = DROP;
              w_inc_drop = rx_frame_axis_tlast;
            end
          endcase
        end
        FWD_IP:  w_fwd_ip  = 1'b1;
        FWD_ARP: w_fwd_arp = 1'b1;
        DROP:    w_inc_drop = rx_frame_axis_tlast && !r_trunc;
      endcase
      if (w_fwd_ip || w_fwd_arp) begin
        if (rx_frame_axis_tlast) begin
          w_user    = w_err;
          w_inc_err = w_err;
          w_inc_ip  = w_fwd_ip && !w_err;
          w_inc_arp = w_fwd_arp && !w_err;
        end else if (w_cnt == LP_MAX) begin
          // Jumbo guard: close the frame early as errored, drop the rest
          w_last    = 1'b1;
          w_user    = 1'b1;
          w_inc_err = 1'b1;
          w_trunc   = 1'b1;
          w_nstate  = DROP;
        end
      end
      if (rx_frame_axis_tlast) begin
        w_nstate = SOF;
      end
    end
  end

  always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      r_state            <= SOF;
      r_beat_cnt         <= '0;
      r_err_seen         <= 1'b0;
      r_trunc            <= 1'b0;
      ip_rx_axis_tdata   <= '0;
      ip_rx_axis_tkeep   <= '0;
      ip_rx_axis_tvalid  <= 1'b0;
      ip_rx_axis_tlast   <= 1'b0;
      ip_rx_axis_tuser   <= 1'b0;
      arp_rx_axis_tdata  <= '0;
      arp_rx_axis_tkeep  <= '0;
      arp_rx_axis_tvalid <= 1'b0;
      arp_rx_axis_tlast  <= 1'b0;
      arp_rx_axis_tuser  <= 1'b0;
      rx_ip_frames       <= '0;
      rx_arp_frames      <= '0;
      rx_drop_frames     <= '0;
      rx_err_frames      <= '0;
    end else begin
      r_state            <= w_nstate;
      ip_rx_axis_tvalid  <= w_fwd_ip;
      ip_rx_axis_tdata   <= w_fwd_ip ? rx_frame_axis_tdata : '0;
      ip_rx_axis_tkeep   <= w_fwd_ip ? rx_frame_axis_tkeep : '0;
      ip_rx_axis_tlast   <= w_fwd_ip && w_last;
      ip_rx_axis_tuser   <= w_fwd_ip && w_user;
      arp_rx_axis_tvalid <= w_fwd_arp;
      arp_rx_axis_tdata  <= w_fwd_arp ? rx_frame_axis_tdata : '0;
      arp_rx_axis_tkeep  <= w_fwd_arp ? rx_frame_axis_tkeep : '0;
      arp_rx_axis_tlast  <= w_fwd_arp && w_last;
      arp_rx_axis_tuser  <= w_fwd_arp && w_user;
      if (rx_frame_axis_tvalid) begin
        if (rx_frame_axis_tlast) begin
          r_beat_cnt <= '0;
          r_err_seen <= 1'b0;
          r_trunc    <= 1'b0;
        end else begin
          r_beat_cnt <= w_cnt;
          r_err_seen <= w_err;
          r_trunc    <= r_trunc | w_trunc;
        end
      end
      if (w_inc_ip)   rx_ip_frames   <= rx_ip_frames + 32'd1;
      if (w_inc_arp)  rx_arp_frames  <= rx_arp_frames + 32'd1;
      if (w_inc_drop) rx_drop_frames <= rx_drop_frames + 32'd1;
      if (w_inc_err)  rx_err_frames  <= rx_err_frames + 32'd1;
    end
  end

endmodule

// File: tb/tb_us_mac_rx_dispatch.sv
// Directed bench for us_mac_rx_dispatch: instance A uses the default
// jumbo guard, instance B a 4-beat guard for the oversize case.
module tb_us_mac_rx_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] td;
  logic [7:0]  tk;
  logic        tv, tu, tl;
  logic [47:0] dst, loc;
  logic [15:0] typ;

  logic [63:0] a_ip_d, a_arp_d, b_ip_d, b_arp_d;
  logic [7:0]  a_ip_k, a_arp_k, b_ip_k, b_arp_k;
  logic        a_ip_v, a_ip_l, a_ip_u, a_arp_v, a_arp_l, a_arp_u;
  logic        b_ip_v, b_ip_l, b_ip_u, b_arp_v, b_arp_l, b_arp_u;
  logic [31:0] a_ipc, a_arpc, a_drc, a_erc;
  logic [31:0] b_ipc, b_arpc, b_drc, b_erc;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [74:0] Z = '0;

  always #5 clk = ~clk;

  us_mac_rx_dispatch u_a (
    .rx_axis_aclk(clk), .rx_axis_aresetn(rst_n),
    .rx_frame_axis_tdata(td), .rx_frame_axis_tkeep(tk),
    .rx_frame_axis_tvalid(tv), .rx_frame_axis_tuser(tu),
    .rx_frame_axis_tlast(tl), .recv_dst_mac_addr(dst),
    .recv_type(typ), .local_mac_addr(loc),
    .ip_rx_axis_tdata(a_ip_d), .ip_rx_axis_tkeep(a_ip_k),
    .ip_rx_axis_tvalid(a_ip_v), .ip_rx_axis_tlast(a_ip_l),
    .ip_rx_axis_tuser(a_ip_u),
    .arp_rx_axis_tdata(a_arp_d), .arp_rx_axis_tkeep(a_arp_k),
    .arp_rx_axis_tvalid(a_arp_v), .arp_rx_axis_tlast(a_arp_l),
    .arp_rx_axis_tuser(a_arp_u),
    .rx_ip_frames(a_ipc), .rx_arp_frames(a_arpc),
    .rx_drop_frames(a_drc), .rx_err_frames(a_erc)
  );

  us_mac_rx_dispatch #(.MAX_BEATS(4)) u_b (
    .rx_axis_aclk(clk), .rx_axis_aresetn(rst_n),
    .rx_frame_axis_tdata(td), .rx_frame_axis_tkeep(tk),
    .rx_frame_axis_tvalid(tv), .rx_frame_axis_tuser(tu),
    .rx_frame_axis_tlast(tl), .recv_dst_mac_addr(dst),
    .recv_type(typ), .local_mac_addr(loc),
    .ip_rx_axis_tdata(b_ip_d), .ip_rx_axis_tkeep(b_ip_k),
    .ip_rx_axis_tvalid(b_ip_v), .ip_rx_axis_tlast(b_ip_l),
    .ip_rx_axis_tuser(b_ip_u),
    .arp_rx_axis_tdata(b_arp_d), .arp_rx_axis_tkeep(b_arp_k),
    .arp_rx_axis_tvalid(b_arp_v), .arp_rx_axis_tlast(b_arp_l),
    .arp_rx_axis_tuser(b_arp_u),
    .rx_ip_frames(b_ipc), .rx_arp_frames(b_arpc),
    .rx_drop_frames(b_drc), .rx_err_frames(b_erc)
  );

  logic [149:0] a_out, b_out;
  logic [127:0] a_cnt, b_cnt;
  assign a_out = {a_ip_v, a_ip_l, a_ip_u, a_ip_k, a_ip_d,
                  a_arp_v, a_arp_l, a_arp_u, a_arp_k, a_arp_d};
  assign b_out = {b_ip_v, b_ip_l, b_ip_u, b_ip_k, b_ip_d,
                  b_arp_v, b_arp_l, b_arp_u, b_arp_k, b_arp_d};
  assign a_cnt = {a_ipc, a_arpc, a_drc, a_erc};
  assign b_cnt = {b_ipc, b_arpc, b_drc, b_erc};

  function automatic logic [74:0] pk(input logic v, input logic l,
                                     input logic u, input logic [7:0] k,
                                     input logic [63:0] d);
    return {v, l, u, k, d};
  endfunction

  function automatic logic [63:0] dat(input int i);
    return 64'hC0DE_0000_0000_0000 + 64'(i);
  endfunction

  function automatic logic [127:0] cn(input int ip, input int arp,
                                      input int drp, input int er);
    return {32'(ip), 32'(arp), 32'(drp), 32'(er)};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic u, input logic l,
                      input logic [7:0] k, input logic [63:0] d);
    tv = v;
    tu = u;
    tl = l;
    tk = k;
    td = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    tv = 1'b0; tu = 1'b0; tl = 1'b0; tk = '0; td = '0;
    loc = 48'h02_00_00_00_00_01;
    dst = loc;
    typ = 16'h0800;
    #12;
    chk("rst_out_a", a_out, {Z, Z});
    chk("rst_cnt_a", a_cnt, cn(0, 0, 0, 0));
    chk("rst_out_b", b_out, {Z, Z});
    rst_n = 1'b1;

    // IP unicast, 4 beats, short last beat
    dst = loc; typ = 16'h0800;
    for (int i = 1; i <= 4; i++) begin
      beat(1'b1, 1'b0, i == 4, (i == 4) ? 8'h07 : 8'hFF, dat(i));
      chk($sformatf("ip_uc_b%0d", i), a_out,
          {pk(1'b1, i == 4, 1'b0, (i == 4) ? 8'h07 : 8'hFF, dat(i)), Z});
    end
    idle();
    chk("ip_uc_idle", a_out, {Z, Z});
    chk("ip_uc_cnt", a_cnt, cn(1, 0, 0, 0));

    // ARP broadcast, single beat
    dst = BCAST; typ = 16'h0806;
    beat(1'b1, 1'b0, 1'b1, 8'hFF, dat(20));
    chk("arp_bc", a_out, {Z, pk(1'b1, 1'b1, 1'b0, 8'hFF, dat(20))});
    idle();
    chk("arp_bc_idle", a_out, {Z, Z});
    chk("arp_bc_cnt", a_cnt, cn(1, 1, 0, 0));

    // Filter drops: foreign dst, then unknown EtherType
    dst = 48'h02_00_00_00_00_99; typ = 16'h0800;
    for (int i = 1; i <= 3; i++) begin
      beat(1'b1, 1'b0, i == 3, 8'hFF, dat(30 + i));
      chk($sformatf("drop_dst_b%0d", i), a_out, {Z, Z});
    end
    dst = loc; typ = 16'h86DD;
    for (int i = 1; i <= 3; i++) begin
      beat(1'b1, i == 2, i == 3, 8'hFF, dat(40 + i));
      chk($sformatf("drop_typ_b%0d", i), a_out, {Z, Z});
    end
    chk("drop_cnt", a_cnt, cn(1, 1, 2, 0));

    // Error frame: tuser on beat 2, gap after beat 3, type changes mid-frame
    dst = loc; typ = 16'h0800;
    for (int i = 1; i <= 3; i++) begin
      beat(1'b1, i == 2, 1'b0, 8'hFF, dat(50 + i));
      chk($sformatf("err_b%0d", i), a_out,
          {pk(1'b1, 1'b0, i == 2, 8'hFF, dat(50 + i)), Z});
    end
    idle();
    chk("err_gap1", a_out, {Z, Z});
    idle();
    chk("err_gap2", a_out, {Z, Z});
    typ = 16'h86DD;
    beat(1'b1, 1'b0, 1'b0, 8'hFF, dat(54));
    chk("err_b4", a_out, {pk(1'b1, 1'b0, 1'b0, 8'hFF, dat(54)), Z});
    beat(1'b1, 1'b0, 1'b1, 8'h0F, dat(55));
    chk("err_b5", a_out, {pk(1'b1, 1'b1, 1'b1, 8'h0F, dat(55)), Z});
    idle();
    chk("err_cnt", a_cnt, cn(1, 1, 2, 1));

    // Oversize on the 4-beat instance
    rst_n = 1'b0;
    #1;
    chk("rst2_cnt_b", b_cnt, cn(0, 0, 0, 0));
    rst_n = 1'b1;
    dst = loc; typ = 16'h0800;
    for (int i = 1; i <= 7; i++) begin
      beat(1'b1, 1'b0, i == 7, 8'hFF, dat(60 + i));
      if (i < 4)
        chk($sformatf("ovs_b%0d", i), b_out,
            {pk(1'b1, 1'b0, 1'b0, 8'hFF, dat(60 + i)), Z});
      else if (i == 4)
        chk("ovs_b4", b_out, {pk(1'b1, 1'b1, 1'b1, 8'hFF, dat(64)), Z});
      else
        chk($sformatf("ovs_b%0d", i), b_out, {Z, Z});
    end
    chk("ovs_cnt", b_cnt, cn(0, 0, 0, 1));
    typ = 16'h0806;
    for (int i = 1; i <= 2; i++) begin
      beat(1'b1, 1'b0, i == 2, 8'hFF, dat(70 + i));
      chk($sformatf("ovs_arp_b%0d", i), b_out,
          {Z, pk(1'b1, i == 2, 1'b0, 8'hFF, dat(70 + i))});
    end
    idle();
    chk("ovs_arp_cnt", b_cnt, cn(0, 1, 0, 1));
    chk("ovs_cnt_a", a_cnt, cn(1, 1, 0, 0));

    // Reset in the middle of an IP frame
    dst = loc; typ = 16'h0800;
    for (int i = 1; i <= 2; i++) begin
      beat(1'b1, 1'b0, 1'b0, 8'hFF, dat(80 + i));
      chk($sformatf("mid_b%0d", i), a_out,
          {pk(1'b1, 1'b0, 1'b0, 8'hFF, dat(80 + i)), Z});
    end
    tv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", a_out, {Z, Z});
    chk("mid_rst_cnt", a_cnt, cn(0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dst = 48'h12_34_56_78_9A_BC; typ = 16'h1234;
    for (int i = 3; i <= 5; i++) begin
      beat(1'b1, 1'b0, i == 5, 8'hFF, dat(80 + i));
      chk($sformatf("mid_tail_b%0d", i), a_out, {Z, Z});
    end
    chk("mid_tail_cnt", a_cnt, cn(0, 0, 1, 0));
    dst = BCAST; typ = 16'h0806;
    beat(1'b1, 1'b0, 1'b1, 8'h3F, dat(90));
    chk("mid_arp", a_out, {Z, pk(1'b1, 1'b1, 1'b0, 8'h3F, dat(90))});
    idle();
    chk("mid_arp_idle", a_out, {Z, Z});
    chk("mid_arp_cnt", a_cnt, cn(0, 1, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
